// File: rtl/timer_pkg.sv
// Shared types and defaults for the seconds-timer run/pause/clear controller.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

    localparam logic [7:0] LimitBcdDefault = 8'h59;

    // States in which the display follows the blink phase instead of staying lit.
    function automatic logic is_blanking(state_e s);
        return (s == ST_PAUSE) || (s == ST_DONE);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw push-button conditioner: 2-FF synchronizer, stability debouncer, rising-edge pulse.
module btn_debounce #(
    parameter int unsigned DB_CYC = 1_000_000
) (
    input  logic clk_i,
    input  logic clr_ni,
    input  logic btn_i,
    output logic rise_o
);

    localparam int unsigned CntW = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;

    logic            sync0_q, sync1_q;
    logic            level_q;
    logic            rise_q;
    logic [CntW-1:0] cnt_q;
    logic            accept;

    // Synced sample has differed from the accepted level for DB_CYC consecutive cycles.
    assign accept = (sync1_q != level_q) && (cnt_q == CntW'(DB_CYC - 1));

    always_ff @(posedge clk_i or negedge clr_ni) begin
        if (!clr_ni) begin
            sync0_q <= 1'b0;
            sync1_q <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync0_q <= btn_i;
            sync1_q <= sync0_q;
            rise_q  <= accept & sync1_q;
            if (sync1_q == level_q) begin
                cnt_q <= '0;
            end else if (accept) begin
                cnt_q   <= '0;
                level_q <= sync1_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/sec_timer_ctrl.sv
// Run/pause/clear sequencer for the BCD seconds counter: debounced buttons, 1 Hz count
// enable, clear pulse and display blink control.
module sec_timer_ctrl
    import timer_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 50_000_000,
    parameter int unsigned DB_CYC    = 1_000_000,
    parameter int unsigned BLINK_DIV = 12_500_000,
    parameter logic [7:0]  LIMIT_BCD = LimitBcdDefault
) (
    input  logic       clk_i,
    input  logic       clr_ni,
    input  logic       btn_run_i,
    input  logic       btn_clr_i,
    input  logic [7:0] cnt_bcd_i,
    output logic       cnt_en_o,
    output logic       cnt_clr_o,
    output logic       disp_blank_o,
    output logic       done_o,
    output logic [1:0] state_o
);

    localparam int unsigned PreW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned BlkW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic run_p, clr_p;

    state_e          state_q, state_d;
    logic [PreW-1:0] presc_q, presc_d;
    logic [BlkW-1:0] blink_cnt_q, blink_cnt_d;
    logic            blink_q, blink_d;
    logic            cnt_en_q, cnt_en_d;
    logic            cnt_clr_q, cnt_clr_d;
    logic            disp_blank_q, done_q;

    btn_debounce #(
        .DB_CYC (DB_CYC)
    ) u_db_run (
        .clk_i  (clk_i),
        .clr_ni (clr_ni),
        .btn_i  (btn_run_i),
        .rise_o (run_p)
    );

    btn_debounce #(
        .DB_CYC (DB_CYC)
    ) u_db_clr (
        .clk_i  (clk_i),
        .clr_ni (clr_ni),
        .btn_i  (btn_clr_i),
        .rise_o (clr_p)
    );

    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        cnt_en_d  = 1'b0;
        cnt_clr_d = 1'b0;
        // Clear outranks everything, including a coincident run press.
        if (clr_p) begin
            state_d   = ST_IDLE;
            presc_d   = '0;
            cnt_clr_d = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (run_p) begin
                        state_d = ST_RUN;
                        presc_d = '0;
                    end
                end
                ST_RUN: begin
                    if (cnt_bcd_i == LIMIT_BCD) begin
                        state_d = ST_DONE;
                    end else begin
                        if (presc_q == PreW'(TICK_DIV - 1)) begin
                            presc_d  = '0;
                            cnt_en_d = 1'b1;
                        end else begin
                            presc_d = presc_q + 1'b1;
                        end
                        if (run_p) begin
                            state_d = ST_PAUSE;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (run_p) begin
                        state_d = ST_RUN;
                    end
                end
                ST_DONE: begin
                end
            endcase
        end
    end

    always_comb begin
        blink_d     = blink_q;
        blink_cnt_d = blink_cnt_q + 1'b1;
        if (blink_cnt_q == BlkW'(BLINK_DIV - 1)) begin
            blink_cnt_d = '0;
            blink_d     = ~blink_q;
        end
    end

    always_ff @(posedge clk_i or negedge clr_ni) begin
        if (!clr_ni) begin
            state_q      <= ST_IDLE;
            presc_q      <= '0;
            blink_cnt_q  <= '0;
            blink_q      <= 1'b0;
            cnt_en_q     <= 1'b0;
            cnt_clr_q    <= 1'b0;
            disp_blank_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            blink_cnt_q  <= blink_cnt_d;
            blink_q      <= blink_d;
            cnt_en_q     <= cnt_en_d;
            cnt_clr_q    <= cnt_clr_d;
            disp_blank_q <= blink_d & is_blanking(state_d);
            done_q       <= (state_d == ST_DONE);
        end
    end

    assign cnt_en_o     = cnt_en_q;
    assign cnt_clr_o    = cnt_clr_q;
    assign disp_blank_o = disp_blank_q;
    assign done_o       = done_q;
    assign state_o      = state_q;

endmodule
